// File: rtl/core_ctrl_fsm.sv
// Multi-cycle control FSM for the AquilaRV32 core: sequences fetch/decode/exec/mem/wb,
// drives memory handshakes, datapath selects and write enables, counts retired instructions.
module core_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             is_rtype,
    input  logic             is_itype,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_branch,
    input  logic             is_jal,
    input  logic             is_jalr,
    input  logic             is_lui,
    input  logic             is_auipc,
    input  logic             branch_taken,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [1:0]       alu_a_sel,
    output logic             alu_b_sel,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam int C_RTYPE  = 0;
    localparam int C_ITYPE  = 1;
    localparam int C_LOAD   = 2;
    localparam int C_STORE  = 3;
    localparam int C_BRANCH = 4;
    localparam int C_JAL    = 5;
    localparam int C_JALR   = 6;
    localparam int C_LUI    = 7;
    localparam int C_AUIPC  = 8;

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            cur;
    logic [8:0]        cls;
    logic [8:0]        flags;
    logic              flags_legal;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        alu_a_cls;
    logic              alu_b_cls;

    assign flags = {is_auipc, is_lui, is_jalr, is_jal, is_branch,
                    is_store, is_load, is_itype, is_rtype};
    // Exactly one class flag must be set for a legal instruction.
    assign flags_legal = (flags != 9'd0) && ((flags & (flags - 9'd1)) == 9'd0);

    assign alu_a_cls = cls[C_LUI] ? 2'd2 :
                       (cls[C_AUIPC] || cls[C_JAL]) ? 2'd1 : 2'd0;
    assign alu_b_cls = !(cls[C_RTYPE] || cls[C_BRANCH]);

    assign state = cur;
    assign trap  = (cur == S_TRAP);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur        <= S_FETCH;
            instret    <= '0;
            trap_cause <= 2'd0;
            cls        <= 9'd0;
            wait_cnt   <= '0;
        end else begin
            if (retire) begin
                instret <= instret + CNT_W'(1);
            end
            case (cur)
                S_FETCH: begin
                    if (imem_ready) begin
                        cur      <= S_DECODE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        cur        <= S_TRAP;
                        trap_cause <= 2'd2;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    cls <= flags;
                    if (flags_legal) begin
                        cur <= S_EXEC;
                    end else begin
                        cur        <= S_TRAP;
                        trap_cause <= 2'd1;
                    end
                end
                S_EXEC: begin
                    wait_cnt <= '0;
                    if (cls[C_BRANCH]) begin
                        cur <= S_FETCH;
                    end else if (cls[C_LOAD] || cls[C_STORE]) begin
                        cur <= S_MEM;
                    end else begin
                        cur <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        wait_cnt <= '0;
                        cur      <= cls[C_STORE] ? S_FETCH : S_WB;
                    end else if (wait_cnt == WAIT_LAST) begin
                        cur        <= S_TRAP;
                        trap_cause <= 2'd3;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_WB: begin
                    cur      <= S_FETCH;
                    wait_cnt <= '0;
                end
                S_TRAP: begin
                    cur <= S_TRAP;
                end
                default: begin
                    cur <= S_FETCH;
                end
            endcase
        end
    end

    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'd0;
        alu_a_sel = 2'd0;
        alu_b_sel = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = 2'd0;
        retire    = 1'b0;
        case (cur)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
            end
            S_EXEC: begin
                alu_a_sel = alu_a_cls;
                alu_b_sel = alu_b_cls;
                if (cls[C_BRANCH]) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken ? 2'd1 : 2'd0;
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                alu_a_sel = alu_a_cls;
                alu_b_sel = alu_b_cls;
                dmem_req  = 1'b1;
                dmem_we   = cls[C_STORE];
                if (dmem_ready && cls[C_STORE]) begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                retire = 1'b1;
                wb_sel = cls[C_LOAD] ? 2'd1 :
                         (cls[C_JAL] || cls[C_JALR]) ? 2'd2 : 2'd0;
                pc_sel = cls[C_JAL] ? 2'd1 : cls[C_JALR] ? 2'd2 : 2'd0;
            end
            default: begin
            end
        endcase
        // Reset silences every request and enable, whatever state is still registered.
        if (rst) begin
            imem_req = 1'b0;
            ir_we    = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            pc_we    = 1'b0;
            reg_we   = 1'b0;
            retire   = 1'b0;
        end
    end

endmodule

// File: doc/core_ctrl_fsm.md
Name: core_ctrl_fsm

Overview:
Multi-cycle control state machine for the AquilaRV32 core.
- Consumes the one-hot instruction-class flags from the type decoder (is_rtype, is_itype, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc).
- Sequences fetch, decode, execute, memory and writeback through the shared datapath.
- Drives the instruction/data memory handshakes, the datapath mux selects and the write enables.
- Keeps a retired-instruction counter and traps on an illegal opcode or a memory timeout.

Parameters:
MEM_TIMEOUT, 16, cycles a memory request may wait for ready before trapping (minimum 1).
CNT_W, 32, width of the instret counter.

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
is_rtype..is_auipc  in  1 each  instruction-class flags from the type decoder; valid while the IR is stable
branch_taken  in  1  branch comparator result, valid in EXEC
imem_req  out  1  instruction fetch request
imem_ready  in  1  fetch data valid this cycle
dmem_req  out  1  data memory request
dmem_we  out  1  data write (store)
dmem_ready  in  1  data access complete this cycle
ir_we  out  1  load instruction register
pc_we  out  1  update PC
pc_sel  out  2  0=pc+4, 1=pc+imm, 2=alu result with bit0 cleared
alu_a_sel  out  2  0=rs1, 1=pc, 2=zero
alu_b_sel  out  1  0=rs2, 1=imm
reg_we  out  1  register file write
wb_sel  out  2  0=alu, 1=mem, 2=pc+4
retire  out  1  one-cycle pulse per completed instruction
instret  out  CNT_W  retired-instruction count
trap  out  1  core halted
trap_cause  out  2  0=none, 1=illegal opcode, 2=imem timeout, 3=dmem timeout
state  out  3  current state, for debug

Behaviour:
States and encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.

Reset:
- rst high on a clock edge sets state=FETCH, instret=0, trap_cause=0, the class register to 0 and the wait counter to 0.
- All outputs are combinational decodes of state and the class register.
- While rst is high, every request and enable output is forced to 0.
- In the first cycle after rst falls, imem_req=1.
- Reset overrides any state, including mid-MEM; an outstanding request is simply dropped.

FETCH:
- imem_req=1.
- When imem_ready=1: ir_we=1 in the same cycle, next state DECODE.
- Otherwise the wait counter increments. When it reaches MEM_TIMEOUT without ready: next state TRAP, trap_cause=2.

DECODE (1 cycle):
- Latch the flags into the class register.
- Illegal if zero flags or more than one flag are set: next state TRAP, trap_cause=1.
- Otherwise next state EXEC.

EXEC (1 cycle), ALU selects by class:
- rtype: a=0, b=0
- itype, load, store, jalr: a=0, b=1
- auipc: a=1, b=1
- lui: a=2, b=1
- branch: a=0, b=0

EXEC transitions:
- branch: pc_we=1, pc_sel=branch_taken?1:0, retire=1, next state FETCH.
- load or store: next state MEM.
- all other classes: next state WB.

MEM:
- dmem_req=1, dmem_we=is_store. ALU selects are held as in EXEC.
- On dmem_ready=1:
  - store: pc_we=1, pc_sel=0, retire=1, next state FETCH.
  - load: next state WB.
- Timeout after MEM_TIMEOUT cycles: next state TRAP, trap_cause=3.

WB (1 cycle):
- reg_we=1, pc_we=1, retire=1, next state FETCH.
- wb_sel: load=1; jal or jalr=2; else 0.
- pc_sel: jal=1; jalr=2; else 0.

Wait counter: cleared on entry to FETCH and to MEM, and whenever ready is seen.

Retire and instret:
- retire is asserted in exactly one cycle per instruction.
- instret increments in that cycle and wraps modulo 2^CNT_W with no saturation.

TRAP:
- Absorbing state: trap=1, all enables and requests 0.
- trap_cause is held until rst.
- Ready inputs are ignored.

Ready outside a request: imem_ready outside FETCH and dmem_ready outside MEM are ignored.

Latency with zero-wait memory:
- rtype, itype, lui, auipc, jal, jalr: 4 cycles (FETCH, DECODE, EXEC, WB).
- branch: 3 cycles.
- store: 4 cycles.
- load: 5 cycles.

Test Plan:
- Reset, then addi (is_itype) with imem_ready tied 1 -> states 0,1,2,4,0; reg_we=1, wb_sel=0 and retire=1 in cycle 4; instret=1.
- lw with dmem_ready asserted 3 cycles after MEM entry -> dmem_req high for 4 cycles with dmem_we=0; WB has wb_sel=1; total 8 cycles; instret increments once.
- beq with branch_taken=1 -> EXEC asserts pc_we=1, pc_sel=1, retire=1; back in FETCH on cycle 4. With branch_taken=0 -> pc_sel=0.
- jalr -> WB asserts wb_sel=2, pc_sel=2; EXEC asserts alu_a_sel=0, alu_b_sel=1.
- All flags 0 in DECODE -> TRAP, trap_cause=1, trap=1. A following imem_ready pulse causes no change. rst returns state to 0 with instret=0.
- MEM_TIMEOUT=4 with imem_ready held 0 -> TRAP after 4 FETCH cycles, trap_cause=2.
- rst pulsed mid-MEM with a store pending -> dmem_req drops, state=0, no retire, instret=0.
